// File: rtl/restoring_divider_16x8_pkg.sv
// -----------------------------------------------------------------------------
// restoring_divider_16x8_pkg
//
// Shared constants for the sequential restoring divider:
//   DIVIDEND_W  - dividend / quotient width, also the number of restoring steps
//   DIVISOR_W   - divisor / remainder width
//   DIV_CNT_W   - width of the step counter (must be able to hold DIVIDEND_W)
//   ST_*        - FSM state encoding
// No ports: this file only holds localparams.
// -----------------------------------------------------------------------------
package restoring_divider_16x8_pkg;

  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W  = 8;
  localparam int DIV_CNT_W  = $clog2(DIVIDEND_W + 1);

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage : restoring_divider_16x8_pkg

// File: rtl/restoring_divider_16x8_step.sv
// -----------------------------------------------------------------------------
// div_restore_step
//
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder, trial-subtract the divisor, keep the difference when
// it is non-negative.
//
// Ports:
//   prem      in  DIVISOR_W  partial remainder entering this step
//   next_bit  in  1          next dividend bit, MSB first
//   divisor   in  DIVISOR_W  divisor (nonzero while stepping)
//   new_prem  out DIVISOR_W  partial remainder leaving this step
//   q_bit     out 1          quotient bit produced by this step
//
// The working remainder is DIVISOR_W+1 bits wide (shifted value and trial).
// Between steps the remainder is always below the divisor, so it is carried
// in DIVISOR_W bits; the extra bit only exists inside the step.
// -----------------------------------------------------------------------------
module div_restore_step #(
  parameter int DIVISOR_W = restoring_divider_16x8_pkg::DIVISOR_W
) (
  input  logic [DIVISOR_W-1:0] prem,
  input  logic                 next_bit,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W-1:0] new_prem,
  output logic                 q_bit
);
  import restoring_divider_16x8_pkg::*;

  logic [DIVISOR_W:0] shifted_s;
  logic [DIVISOR_W:0] trial_s;

  // Shift, trial subtract, restore when the trial went negative
  always_comb begin
    shifted_s = {prem, next_bit};
    trial_s   = shifted_s - {1'b0, divisor};
    // MSB of the trial is the borrow: 0 means shifted >= divisor
    q_bit     = ~trial_s[DIVISOR_W];
    if (q_bit) begin
      new_prem = trial_s[DIVISOR_W-1:0];
    end else begin
      new_prem = shifted_s[DIVISOR_W-1:0];
    end
  end

endmodule : div_restore_step

// File: rtl/restoring_divider_16x8.sv
// -----------------------------------------------------------------------------
// restoring_divider_16x8
//
// Sequential unsigned restoring divider, one quotient bit per clock, with a
// valid/ready handshake on both sides and a single operation in flight.
//
// Ports:
//   clk          in  1           rising-edge clock
//   reset        in  1           synchronous, active-high reset
//   in_valid     in  1           dividend/divisor valid
//   in_ready     out 1           block can accept an operation (IDLE only)
//   dividend     in  DIVIDEND_W  numerator
//   divisor      in  DIVISOR_W   denominator
//   out_valid    out 1           results valid (DONE only)
//   out_ready    in  1           consumer accepts the results
//   quotient     out DIVIDEND_W  dividend / divisor (all ones on divide by 0)
//   remainder    out DIVISOR_W   dividend % divisor (low dividend bits on /0)
//   div_by_zero  out 1           the completed operation had divisor == 0
//
// Timing: a nonzero-divisor operation accepted at edge T0 steps on edges
// T1..T(DIVIDEND_W) and presents results after the last step. A zero divisor
// skips the steps and presents results right after the accept edge.
// -----------------------------------------------------------------------------
module restoring_divider_16x8 #(
  parameter int DIVIDEND_W = restoring_divider_16x8_pkg::DIVIDEND_W,
  parameter int DIVISOR_W  = restoring_divider_16x8_pkg::DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);
  import restoring_divider_16x8_pkg::*;

  localparam int               CNT_W     = $clog2(DIVIDEND_W + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIVIDEND_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [1:0]            state_r;
  logic [1:0]            state_nxt_s;
  logic [CNT_W-1:0]      cnt_r;
  logic [DIVISOR_W-1:0]  divisor_r;
  logic [DIVISOR_W-1:0]  prem_r;
  logic [DIVIDEND_W-1:0] quo_r;
  logic                  dbz_r;
  logic                  in_ready_r;
  logic                  out_valid_r;
  logic                  accept_s;
  logic                  divisor_zero_s;
  logic [DIVISOR_W-1:0]  step_prem_s;
  logic                  step_qbit_s;

  // The single trial-subtract stage, iterated once per CALC cycle. The
  // dividend shift register feeds its MSB in and collects quotient bits at
  // the LSB, so after DIVIDEND_W steps it holds the full quotient.
  div_restore_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .prem     (prem_r),
    .next_bit (quo_r[DIVIDEND_W-1]),
    .divisor  (divisor_r),
    .new_prem (step_prem_s),
    .q_bit    (step_qbit_s)
  );

  // Input handshake qualifiers
  always_comb begin
    accept_s       = in_valid & in_ready_r;
    divisor_zero_s = (divisor == {DIVISOR_W{1'b0}});
  end

  // FSM next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = divisor_zero_s ? ST_DONE : ST_CALC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (cnt_r == LAST_STEP) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_CALC;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register and handshake flags, registered from the next state so
  // both flags are pure state decodes with no input-to-output path
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == ST_IDLE);
      out_valid_r <= (state_nxt_s == ST_DONE);
    end
  end

  // Operand capture, iteration and result holding
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r     <= {CNT_W{1'b0}};
      divisor_r <= {DIVISOR_W{1'b0}};
      prem_r    <= {DIVISOR_W{1'b0}};
      quo_r     <= {DIVIDEND_W{1'b0}};
      dbz_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            cnt_r <= {CNT_W{1'b0}};
            if (divisor_zero_s) begin
              // Divide by zero: saturated quotient, low dividend bits as
              // remainder, no stepping
              divisor_r <= {DIVISOR_W{1'b0}};
              prem_r    <= dividend[DIVISOR_W-1:0];
              quo_r     <= {DIVIDEND_W{1'b1}};
              dbz_r     <= 1'b1;
            end else begin
              divisor_r <= divisor;
              prem_r    <= {DIVISOR_W{1'b0}};
              quo_r     <= dividend;
              dbz_r     <= 1'b0;
            end
          end else begin
            cnt_r <= cnt_r;
          end
        end
        ST_CALC: begin
          quo_r  <= {quo_r[DIVIDEND_W-2:0], step_qbit_s};
          prem_r <= step_prem_s;
          cnt_r  <= cnt_r + CNT_ONE;
        end
        ST_DONE: begin
          // Results hold until the consumer takes them
          cnt_r <= cnt_r;
        end
        default: begin
          cnt_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Output mapping: every output is a register
  always_comb begin
    in_ready    = in_ready_r;
    out_valid   = out_valid_r;
    quotient    = quo_r;
    remainder   = prem_r;
    div_by_zero = dbz_r;
  end

endmodule : restoring_divider_16x8

// File: doc/restoring_divider_16x8.md
# restoring_divider_16x8

Sequential restoring divider: the inverse of the team's 8x8 combinational multiplier. It divides a 16-bit dividend by an 8-bit divisor, producing a 16-bit quotient and an 8-bit remainder, one quotient bit per clock. It sits beside the multiplier in the other-blocks arithmetic library, for the decoder-side range/CDF paths that need `x / d` rather than `a * b`. It uses a valid/ready handshake on both input and output.

## Interface
- `DIVIDEND_W`, default 16: dividend and quotient width; also the iteration count.
- `DIVISOR_W`, default 8: divisor and remainder width.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high reset.
- `in_valid` input 1: dividend/divisor valid.
- `in_ready` output 1: block can accept an operation.
- `dividend` input DIVIDEND_W: numerator.
- `divisor` input DIVISOR_W: denominator.
- `out_valid` output 1: results valid.
- `out_ready` input 1: consumer accepts the results.
- `quotient` output DIVIDEND_W: `dividend / divisor`.
- `remainder` output DIVISOR_W: `dividend % divisor`.
- `div_by_zero` output 1: the operation had `divisor == 0`.

## Operation
- **FSM states:** IDLE, CALC, DONE.
- **IDLE:** `in_ready = 1`.
  - `in_valid & in_ready` latches the operands.
  - Divisor nonzero: go to CALC and clear the iteration counter.
  - Divisor zero: go straight to DONE with `quotient = all ones`, `remainder = dividend[DIVISOR_W-1:0]`, `div_by_zero = 1`.
- **CALC:** one restoring step per cycle, MSB first.
  - Partial remainder is `DIVISOR_W+1` bits wide.
  - Trial = `{prem[DIVISOR_W-1:0], next dividend bit} - {1'b0, divisor}`.
  - Trial non-negative (MSB 0): prem takes the trial and the quotient bit is 1.
  - Otherwise: prem takes the shifted value and the quotient bit is 0.
  - The dividend shift register doubles as the quotient register.
  - After `DIVIDEND_W` steps, go to DONE.
- **DONE:**
  - `out_valid = 1`.
  - `quotient`, `remainder` and `div_by_zero` stay stable until `out_ready`.
  - `out_valid & out_ready` returns to IDLE.
- **Single operation in flight:** `in_ready = 0` in CALC and DONE. `in_valid` is ignored in those states and operands are not sampled.
- **No overlap:** accept and output handshakes never coincide. A new operation can be accepted at the earliest in the cycle after DONE→IDLE.
- **Arithmetic:** unsigned only. `remainder < divisor` always holds for a nonzero divisor. The quotient never overflows because its width equals the dividend width.

## Timing
- **Reset values** (synchronous, takes effect on the edge where `reset = 1`, overriding everything):
  - State is IDLE.
  - `in_ready = 1`.
  - `out_valid = 0`.
  - `quotient = 0`, `remainder = 0`, `div_by_zero = 0`.
  - Iteration counter is 0.
- **Reset mid-CALC or mid-DONE:** the operation is discarded with no `out_valid` pulse. The cycle after the reset edge shows `in_ready = 1`.
- **Latency, nonzero divisor:** accept at edge T0. CALC occupies edges T1..T16. `out_valid` is high from the cycle after T16, so latency is `DIVIDEND_W` cycles.
- **Latency, zero divisor:** `out_valid` is high in the cycle after T0 (1 cycle).
- **Throughput:** at best one operation per `DIVIDEND_W+2` cycles (accept, compute, drain).
- **Outputs:** all registered; there is no combinational path from inputs to outputs.
  - `in_ready` decodes from state only.
  - `out_valid` decodes from state only.
- **Back-pressure:** `out_ready = 0` holds DONE indefinitely with outputs unchanged.

## Structure
- **Shared arithmetic package / header:**
  - Width localparams `DIVIDEND_W` and `DIVISOR_W`.
  - FSM state encoding: IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2.
  - Counter width `$clog2(DIVIDEND_W+1)`.
- **Sub-module `div_restore_step`:** combinational, one trial subtract.
  - Inputs: prem, next bit, divisor.
  - Outputs: new prem, quotient bit.
  - The top instantiates exactly one and iterates it sequentially.
- **Top:** FSM, counter, operand, prem and quotient registers, handshake decode.

## Test plan
- **Exact inverse of multiply:** `0x0E10 / 0x0F` → `quotient = 0x00F0`, `remainder = 0x00`, `div_by_zero = 0`. `out_valid` rises exactly 16 cycles after the accept edge.
- **General and small cases:**
  - `0x03E8 / 0x07` → `0x008E` rem `0x06`.
  - `0x0005 / 0x09` → `0x0000` rem `0x05`.
- **Extremes:**
  - `0xFFFF / 0x01` → `0xFFFF` rem `0x00`.
  - `0xFFFF / 0xFF` → `0x0101` rem `0x00`.
- **Divide by zero:** `0x1234 / 0x00` → `quotient = 0xFFFF`, `remainder = 0x34`, `div_by_zero = 1`. `out_valid` is high in the cycle after accept.
- **Back-pressure:** hold `out_ready = 0` for 5 cycles in DONE while driving `in_valid = 1` with new operands.
  - Outputs stay stable and `in_ready = 0`.
  - Release → IDLE next cycle; only then is the new operation accepted.
- **Reset mid-operation:** assert `reset` at the 8th CALC cycle.
  - Next cycle: `in_ready = 1`, `out_valid = 0`, all outputs 0.
  - A following `0x03E8 / 0x07` completes correctly.
- **Random:** 10k random operand pairs compared against a `/` and `%` reference model.
